// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CHECK   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

endpackage

// File: rtl/prog_loader_if.sv
// Word stream in, instruction-memory write port out; master is the loader side.
interface prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader_release_timer.sv
// Down-counter that keeps the core in reset for HOLD cycles after a good load.
module prog_loader_release_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= CW'(HOLD - 1);
    else if (en && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/prog_loader.sv
// Streams words into instruction memory, verifies a checksum, then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic              abort,
  prog_loader_if.master     bus,
  output logic              cpu_reset,
  output logic              run_mode,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W + 2)'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W:0]   index, index_n, count_q, count_n;
  logic [ADDR_W-1:0] base_q, base_n, addr_q, addr_n;
  logic [DATA_W-1:0] sum, sum_n, exp_q, exp_n, wdata_q, wdata_n;
  logic              we_q, we_n, cpu_reset_n, run_n, done_n, err_n;
  logic [1:0]        code_n;
  logic              accept, range_bad, timer_load, timer_tc;
  logic [ADDR_W+1:0] range_end;

  assign bus.s_ready = (state == LOAD);
  assign bus.mem_we  = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign accept    = bus.s_valid && (state == LOAD);
  // Range sum is two bits wider than the address so it cannot wrap.
  assign range_end = {2'b00, base_addr} + {1'b0, word_count};
  assign range_bad = (word_count == '0) || (range_end > DEPTH_L);

  prog_loader_release_timer #(.HOLD(RST_HOLD)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (state == RELEASE),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      sum       <= '0;
      count_q   <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_reset <= 1'b1;
      run_mode  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_n;
      index     <= index_n;
      sum       <= sum_n;
      count_q   <= count_n;
      base_q    <= base_n;
      exp_q     <= exp_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      cpu_reset <= cpu_reset_n;
      run_mode  <= run_n;
      done      <= done_n;
      err       <= err_n;
      err_code  <= code_n;
    end
  end

  always_comb begin
    state_n     = state;
    index_n     = index;
    sum_n       = sum;
    count_n     = count_q;
    base_n      = base_q;
    exp_n       = exp_q;
    we_n        = 1'b0;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    cpu_reset_n = cpu_reset;
    run_n       = run_mode;
    done_n      = 1'b0;
    err_n       = err;
    code_n      = err_code;
    timer_load  = 1'b0;

    case (state)
      IDLE: begin
        // A new start always parks the core, even one that is already running.
        if (start) begin
          base_n      = base_addr;
          count_n     = word_count;
          exp_n       = exp_sum;
          index_n     = '0;
          sum_n       = '0;
          err_n       = 1'b0;
          code_n      = ERR_NONE;
          run_n       = 1'b0;
          cpu_reset_n = 1'b1;
          if (range_bad) begin
            err_n  = 1'b1;
            code_n = ERR_RANGE;
            done_n = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n     = IDLE;
          err_n       = 1'b1;
          code_n      = ERR_ABORT;
          done_n      = 1'b1;
          run_n       = 1'b0;
          cpu_reset_n = 1'b1;
        end else if (accept) begin
          we_n    = 1'b1;
          addr_n  = base_q + index[ADDR_W-1:0];
          wdata_n = bus.s_data;
          sum_n   = sum + bus.s_data;
          index_n = index + (ADDR_W + 1)'(1);
          if (index + (ADDR_W + 1)'(1) == count_q)
            state_n = CHECK;
        end
      end
      CHECK: begin
        if (sum == exp_q) begin
          state_n    = RELEASE;
          timer_load = 1'b1;
        end else begin
          state_n     = IDLE;
          err_n       = 1'b1;
          code_n      = ERR_SUM;
          done_n      = 1'b1;
          run_n       = 1'b0;
          cpu_reset_n = 1'b1;
        end
      end
      RELEASE: begin
        if (timer_tc) begin
          state_n     = IDLE;
          cpu_reset_n = 1'b0;
          run_n       = 1'b1;
          done_n      = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader with hand-computed expectations.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic [31:0] exp_sum = '0;
  logic        abort = 1'b0;
  logic        cpu_reset, run_mode, done, err;
  logic [1:0]  err_code;

  prog_loader_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .exp_sum    (exp_sum),
    .abort      (abort),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .run_mode   (run_mode),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  cnt;
    logic [31:0] d0;
    logic [31:0] step;
    int          gap;
    int          sends;
    int          abort_at;
    logic [31:0] exp_sum;
    logic [1:0]  exp_code;
    int          exp_writes;
    int          exp_lat;
    logic        exp_run;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic [1:0] snap_code;
  logic snap_err, snap_run, snap_cpurst, snap_ready;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port and the done pulse mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (done) begin
      done_count  = done_count + 1;
      done_cyc    = cyc;
      snap_code   = err_code;
      snap_err    = err;
      snap_run    = run_mode;
      snap_cpurst = cpu_reset;
      snap_ready  = bus.s_ready;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int dc0, t0, waited;
    dc0 = done_count;
    wr_addr.delete();
    wr_data.delete();
    tick();
    start = 1'b1; base_addr = v.base; word_count = v.cnt; exp_sum = v.exp_sum;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < v.sends; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = v.d0 + 32'(i) * v.step;
      abort       = (i == v.abort_at);
      tick();
      bus.s_valid = 1'b0;
      abort       = 1'b0;
      if (i < v.sends - 1)
        repeat (v.gap) tick();
    end
    waited = 0;
    while (done_count == dc0 && waited < 100) begin
      tick();
      waited++;
    end
    if (done_count == dc0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL %s timeout: no done after %0d cycles", name, waited);
      return;
    end
    checkOutput({name, " latency"}, 32'(done_cyc - t0), 32'(v.exp_lat));
    checkOutput({name, " err_code"}, 32'(snap_code), 32'(v.exp_code));
    checkOutput({name, " err"}, 32'(snap_err), 32'(v.exp_code != ERR_NONE));
    checkOutput({name, " run_mode"}, 32'(snap_run), 32'(v.exp_run));
    checkOutput({name, " cpu_reset"}, 32'(snap_cpurst), 32'(!v.exp_run));
    checkOutput({name, " s_ready after done"}, 32'(snap_ready), 32'd0);
    repeat (3) tick();
    checkOutput({name, " done pulses"}, 32'(done_count - dc0), 32'd1);
    checkOutput({name, " write count"}, 32'(wr_addr.size()), 32'(v.exp_writes));
    for (int k = 0; k < v.exp_writes && k < wr_addr.size(); k++) begin
      checkOutput($sformatf("%s addr[%0d]", name, k), 32'(wr_addr[k]), 32'(v.base + 8'(k)));
      checkOutput($sformatf("%s data[%0d]", name, k), wr_data[k], v.d0 + 32'(k) * v.step);
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " s_ready"}, 32'(bus.s_ready), 32'd0);
    checkOutput({name, " mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({name, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({name, " mem_wdata"}, bus.mem_wdata, 32'd0);
    checkOutput({name, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    checkOutput({name, " run_mode"}, 32'(run_mode), 32'd0);
    checkOutput({name, " done"}, 32'(done), 32'd0);
    checkOutput({name, " err"}, 32'(err), 32'd0);
    checkOutput({name, " err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    int dc;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    //          base cnt  d0            step gap snd abt sum         code       wr lat run
    vecs[0] = '{8'd0,   9'd11, 32'd1,        32'd1, 0, 11, -1, 32'd66,   ERR_NONE,  11, 17, 1'b1};
    vecs[1] = '{8'd8,   9'd3,  32'hA,        32'd1, 2, 3,  -1, 32'h21,   ERR_NONE,  3,  13, 1'b1};
    vecs[2] = '{8'd20,  9'd2,  32'hFFFFFFFF, 32'd3, 0, 2,  -1, 32'h2,    ERR_SUM,   2,  4,  1'b0};
    vecs[3] = '{8'd250, 9'd7,  32'd0,        32'd1, 0, 0,  -1, 32'd0,    ERR_RANGE, 0,  1,  1'b0};
    vecs[4] = '{8'd40,  9'd5,  32'd7,        32'd1, 0, 3,  2,  32'd45,   ERR_ABORT, 2,  4,  1'b0};
    vecs[5] = '{8'd250, 9'd6,  32'd100,      32'd1, 0, 6,  -1, 32'd615,  ERR_NONE,  6,  12, 1'b1};

    #1 reset = 1'b1;
    #2 checkResetValues("reset");
    tick();
    tick();
    reset = 1'b0;

    for (int n = 0; n < 6; n++)
      applyStimulus(vecs[n], $sformatf("vec%0d", n));

    // Abort while idle must leave the running core alone.
    dc = done_count;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    checkOutput("idle abort run_mode", 32'(run_mode), 32'd1);
    checkOutput("idle abort cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("idle abort err", 32'(err), 32'd0);
    checkOutput("idle abort done", 32'(done_count - dc), 32'd0);

    // Reset in the middle of a 10-word load, then a clean reload.
    tick();
    start = 1'b1; base_addr = 8'd0; word_count = 9'd10; exp_sum = 32'd55;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(i + 1);
      tick();
    end
    bus.s_valid = 1'b0;
    checkOutput("midload s_ready", 32'(bus.s_ready), 32'd1);
    #2 reset = 1'b1;
    #1 checkResetValues("midload reset");
    tick();
    reset = 1'b0;
    applyStimulus(vecs[0], "reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
